// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the per-axis phase enum.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned POS_W       = 10;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Sync + position bus from the VGA timing generator to the pixel drawers.
// o_frame_count is present only when VGA_SYNC_FRAME_COUNT_EN is defined.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             o_hSync;
  logic             o_vSync;
  logic [POS_W-1:0] o_display_x_pos;
  logic [POS_W-1:0] o_display_y_pos;
  logic             o_active;
  logic             o_line_start;
  logic             o_frame_start;

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] o_frame_count;

  modport master (output o_hSync, o_vSync, o_display_x_pos, o_display_y_pos,
                         o_active, o_line_start, o_frame_start, o_frame_count);
  modport slave  (input  o_hSync, o_vSync, o_display_x_pos, o_display_y_pos,
                         o_active, o_line_start, o_frame_start, o_frame_count);
`else
  modport master (output o_hSync, o_vSync, o_display_x_pos, o_display_y_pos,
                         o_active, o_line_start, o_frame_start);
  modport slave  (input  o_hSync, o_vSync, o_display_x_pos, o_display_y_pos,
                         o_active, o_line_start, o_frame_start);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus the phase of the position
// it will hold after the current clock, and a flag marking the last position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE,
  parameter int unsigned FP     = H_FP,
  parameter int unsigned SYNC   = H_SYNC,
  parameter int unsigned BP     = H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output phase_e           phase_nxt_c,
  output logic             wrap_c
);

  localparam int unsigned      TOTAL       = ACTIVE + FP + SYNC + BP;
  localparam logic [POS_W-1:0] LAST        = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] FRONT_START = POS_W'(ACTIVE);
  localparam logic [POS_W-1:0] SYNC_START  = POS_W'(ACTIVE + FP);
  localparam logic [POS_W-1:0] BACK_START  = POS_W'(ACTIVE + FP + SYNC);

  logic [POS_W-1:0] pos_nxt_c;

  assign wrap_c = (pos == LAST);

  // Next position and the phase it falls in; outputs downstream are registered from these.
  always_comb begin
    pos_nxt_c   = pos;
    phase_nxt_c = PH_ACTIVE;
    if (en) begin
      pos_nxt_c = wrap_c ? '0 : pos + POS_W'(1);
    end
    if (pos_nxt_c >= BACK_START) begin
      phase_nxt_c = PH_BACK;
    end else if (pos_nxt_c >= SYNC_START) begin
      phase_nxt_c = PH_SYNC;
    end else if (pos_nxt_c >= FRONT_START) begin
      phase_nxt_c = PH_FRONT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else begin
      pos <= pos_nxt_c;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: syncs, raw x/y and pixel qualifiers.
// Optional VGA_SYNC_FRAME_COUNT_EN adds an 8-bit wrapping frame counter.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CFG_H_ACTIVE = H_ACTIVE,
  parameter int unsigned CFG_H_FP     = H_FP,
  parameter int unsigned CFG_H_SYNC   = H_SYNC,
  parameter int unsigned CFG_H_BP     = H_BP,
  parameter int unsigned CFG_V_ACTIVE = V_ACTIVE,
  parameter int unsigned CFG_V_FP     = V_FP,
  parameter int unsigned CFG_V_SYNC   = V_SYNC,
  parameter int unsigned CFG_V_BP     = V_BP
) (
  input  logic           i_CLK,
  input  logic           i_RST_N,
  input  logic           i_enable,
  vga_sync_gen_if.master bus
);

  // run is low until the first enabled edge, which presents pixel (0,0) without advancing.
  logic   run;
  logic   h_en_c;
  logic   v_en_c;
  logic   h_wrap_c;
  logic   v_wrap_c;
  phase_e h_phase_nxt_c;
  phase_e v_phase_nxt_c;

  assign h_en_c = i_enable & run;
  assign v_en_c = h_en_c & h_wrap_c;

  vga_axis_counter #(
    .ACTIVE(CFG_H_ACTIVE), .FP(CFG_H_FP), .SYNC(CFG_H_SYNC), .BP(CFG_H_BP)
  ) u_h_cnt (
    .clk        (i_CLK),
    .rst_n      (i_RST_N),
    .en         (h_en_c),
    .pos        (bus.o_display_x_pos),
    .phase_nxt_c(h_phase_nxt_c),
    .wrap_c     (h_wrap_c)
  );

  vga_axis_counter #(
    .ACTIVE(CFG_V_ACTIVE), .FP(CFG_V_FP), .SYNC(CFG_V_SYNC), .BP(CFG_V_BP)
  ) u_v_cnt (
    .clk        (i_CLK),
    .rst_n      (i_RST_N),
    .en         (v_en_c),
    .pos        (bus.o_display_y_pos),
    .phase_nxt_c(v_phase_nxt_c),
    .wrap_c     (v_wrap_c)
  );

  // Qualifiers registered from the next pixel so they line up with x/y.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      run               <= 1'b0;
      bus.o_hSync       <= 1'b1;
      bus.o_vSync       <= 1'b1;
      bus.o_active      <= 1'b0;
      bus.o_line_start  <= 1'b0;
      bus.o_frame_start <= 1'b0;
    end else if (i_enable) begin
      run               <= 1'b1;
      bus.o_hSync       <= (h_phase_nxt_c != PH_SYNC);
      bus.o_vSync       <= (v_phase_nxt_c != PH_SYNC);
      bus.o_active      <= (h_phase_nxt_c == PH_ACTIVE) && (v_phase_nxt_c == PH_ACTIVE);
      bus.o_line_start  <= ~run | h_wrap_c;
      bus.o_frame_start <= ~run | (h_wrap_c & v_wrap_c);
    end
  end

`ifdef VGA_SYNC_FRAME_COUNT_EN
  // Counts frame wraps only; the first frame after reset leaves it at 0.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      bus.o_frame_count <= '0;
    end else if (h_en_c & h_wrap_c & v_wrap_c) begin
      bus.o_frame_count <= bus.o_frame_count + FRAME_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full 640x480 instance plus a shrunken-timing instance
// so whole frames fit in a short run; both checked against a pixel-level model.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;

  int errors = 0;
  int checks = 0;

  always #20 clk = ~clk;

  vga_sync_gen_if bus0 ();
  vga_sync_gen_if bus1 ();

  vga_sync_gen u_dut0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_enable(en0), .bus(bus0)
  );

  vga_sync_gen #(
    .CFG_H_ACTIVE(8), .CFG_H_FP(2), .CFG_H_SYNC(3), .CFG_H_BP(3),
    .CFG_V_ACTIVE(6), .CFG_V_FP(2), .CFG_V_SYNC(2), .CFG_V_BP(3)
  ) u_dut1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_enable(en1), .bus(bus1)
  );

  // Timing of each instance and model state: which pixel it should be showing.
  int ha [2] = '{640, 8};
  int hf [2] = '{16, 2};
  int hsw[2] = '{96, 3};
  int hb [2] = '{48, 3};
  int va [2] = '{480, 6};
  int vf [2] = '{10, 2};
  int vsw[2] = '{2, 2};
  int vb [2] = '{33, 3};

  int mx [2] = '{0, 0};
  int my [2] = '{0, 0};
  bit mrun[2] = '{1'b0, 1'b0};
  int mfc[2] = '{0, 0};

  function automatic void model_reset(input int d);
    mx[d] = 0; my[d] = 0; mrun[d] = 1'b0; mfc[d] = 0;
  endfunction

  function automatic void model_step(input int d, input bit en);
    int ht, vt;
    ht = ha[d] + hf[d] + hsw[d] + hb[d];
    vt = va[d] + vf[d] + vsw[d] + vb[d];
    if (!en) return;
    if (!mrun[d]) begin
      mrun[d] = 1'b1;
      return;
    end
    mx[d] = mx[d] + 1;
    if (mx[d] == ht) begin
      mx[d] = 0;
      my[d] = my[d] + 1;
      if (my[d] == vt) begin
        my[d] = 0;
        mfc[d] = (mfc[d] + 1) % 256;
      end
    end
  endfunction

  // {x, y, hSync, vSync, active, line_start, frame_start, frame_count}
  function automatic logic [32:0] exp_vec(input int d);
    int x, y;
    bit h_low, v_low, act;
    logic [7:0] fc;
    x = mx[d]; y = my[d];
    h_low = (x >= ha[d] + hf[d]) && (x < ha[d] + hf[d] + hsw[d]);
    v_low = (y >= va[d] + vf[d]) && (y < va[d] + vf[d] + vsw[d]);
    act   = (x < ha[d]) && (y < va[d]);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    fc = 8'(mfc[d]);
`else
    fc = 8'd0;
`endif
    if (!mrun[d])
      return {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fc};
    return {10'(x), 10'(y), !h_low, !v_low, act, (x == 0), (x == 0 && y == 0), fc};
  endfunction

  function automatic logic [32:0] got_vec(input int d);
    logic [7:0] fc;
    fc = 8'd0;
    if (d == 0) begin
`ifdef VGA_SYNC_FRAME_COUNT_EN
      fc = bus0.o_frame_count;
`endif
      return {bus0.o_display_x_pos, bus0.o_display_y_pos, bus0.o_hSync, bus0.o_vSync,
              bus0.o_active, bus0.o_line_start, bus0.o_frame_start, fc};
    end
`ifdef VGA_SYNC_FRAME_COUNT_EN
    fc = bus1.o_frame_count;
`endif
    return {bus1.o_display_x_pos, bus1.o_display_y_pos, bus1.o_hSync, bus1.o_vSync,
            bus1.o_active, bus1.o_line_start, bus1.o_frame_start, fc};
  endfunction

  // One clock: enables set before the edge, model advanced, outputs settle 1ns after.
  task automatic tick(input bit e0, input bit e1);
    en0 = e0; en1 = e1;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      else model_step(d, (d == 0) ? e0 : e1);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset(0); model_reset(1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_vec(d) !== exp_vec(d)) begin
        errors++;
        $display("FAIL reset dut%0d: got %h expected %h", d, got_vec(d), exp_vec(d));
      end
    end
  endtask

  task automatic test_first_pixel();
    rst_n = 1'b1;
    tick(1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_vec(d) !== exp_vec(d)) begin
        errors++;
        $display("FAIL first_pixel dut%0d: got %h expected %h", d, got_vec(d), exp_vec(d));
      end
    end
    checks++;
    if ({bus0.o_display_x_pos, bus0.o_display_y_pos, bus0.o_active, bus0.o_line_start,
         bus0.o_frame_start, bus0.o_hSync, bus0.o_vSync} !== {10'd0, 10'd0, 5'b11111}) begin
      errors++;
      $display("FAIL first_pixel_flags: got x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b",
               bus0.o_display_x_pos, bus0.o_display_y_pos, bus0.o_active,
               bus0.o_line_start, bus0.o_frame_start, bus0.o_hSync, bus0.o_vSync);
    end
  endtask

  task automatic test_line();
    int hs_low_cnt, act_cnt;
    hs_low_cnt = (bus0.o_hSync == 1'b0) ? 1 : 0;
    act_cnt    = (bus0.o_active == 1'b1) ? 1 : 0;
    for (int i = 1; i < 800; i++) begin
      tick(1'b1, 1'b1);
      if (bus0.o_hSync == 1'b0) hs_low_cnt++;
      if (bus0.o_active == 1'b1) act_cnt++;
      checks++;
      if (got_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL line x=%0d: got %h expected %h", i, got_vec(0), exp_vec(0));
      end
    end
    checks++;
    if (hs_low_cnt !== 96) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected 96", hs_low_cnt);
    end
    checks++;
    if (act_cnt !== 640) begin
      errors++;
      $display("FAIL active_width: got %0d expected 640", act_cnt);
    end
    tick(1'b1, 1'b1);
    checks++;
    if ({bus0.o_display_x_pos, bus0.o_display_y_pos, bus0.o_line_start, bus0.o_frame_start}
        !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL line_wrap: got x=%0d y=%0d ls=%b fs=%b expected x=0 y=1 ls=1 fs=0",
               bus0.o_display_x_pos, bus0.o_display_y_pos, bus0.o_line_start, bus0.o_frame_start);
    end
  endtask

  task automatic test_enable_freeze();
    for (int i = 0; i < 2000 && mx[0] != 655; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (got_vec(0) !== exp_vec(0) || bus0.o_display_x_pos !== 10'd655) begin
        errors++;
        $display("FAIL freeze cycle %0d: got %h expected %h", i, got_vec(0), exp_vec(0));
      end
    end
    tick(1'b1, 1'b1);
    checks++;
    if ({bus0.o_display_x_pos, bus0.o_hSync} !== {10'd656, 1'b0}) begin
      errors++;
      $display("FAIL resume_hsync: got x=%0d hs=%b expected x=656 hs=0",
               bus0.o_display_x_pos, bus0.o_hSync);
    end
  endtask

  // Small instance: one full frame from a frame start, vsync width and wrap.
  task automatic test_frame();
    int vs_low_cnt;
    logic [7:0] fc0;
    vs_low_cnt = 0;
    for (int i = 0; i < 500 && !(mrun[1] && mx[1] == 0 && my[1] == 0); i++)
      tick(1'b1, 1'b1);
    fc0 = 8'(mfc[1]);
    for (int i = 0; i < 16 * 13; i++) begin
      tick(1'b1, 1'b1);
      if (bus1.o_vSync == 1'b0) vs_low_cnt++;
      checks++;
      if (got_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL frame step %0d: got %h expected %h", i, got_vec(1), exp_vec(1));
      end
    end
    checks++;
    if (vs_low_cnt !== 32) begin
      errors++;
      $display("FAIL vsync_width: got %0d expected 32", vs_low_cnt);
    end
    checks++;
    if ({bus1.o_display_x_pos, bus1.o_display_y_pos, bus1.o_frame_start} !== {10'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b expected 0 0 1",
               bus1.o_display_x_pos, bus1.o_display_y_pos, bus1.o_frame_start);
    end
`ifdef VGA_SYNC_FRAME_COUNT_EN
    checks++;
    if (bus1.o_frame_count !== fc0 + 8'd1) begin
      errors++;
      $display("FAIL frame_count: got %0d expected %0d", bus1.o_frame_count, fc0 + 8'd1);
    end
`else
    if (fc0 != 8'd0) $display("note: model frame count %0d", fc0);
`endif
  endtask

  task automatic test_back_to_back();
    bit e0, e1;
    for (int i = 0; i < 1500; i++) begin
      e0 = ($urandom_range(0, 3) != 0);
      e1 = ($urandom_range(0, 3) != 0);
      tick(e0, e1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random dut%0d step %0d: got %h expected %h", d, i, got_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    #5 rst_n = 1'b0;
    model_reset(0); model_reset(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_vec(d) !== exp_vec(d)) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h expected %h", d, got_vec(d), exp_vec(d));
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_vec(d) !== exp_vec(d)) begin
        errors++;
        $display("FAIL restart dut%0d: got %h expected %h", d, got_vec(d), exp_vec(d));
      end
    end
    checks++;
    if ({bus0.o_display_x_pos, bus0.o_display_y_pos, bus0.o_frame_start} !== {10'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_origin: got x=%0d y=%0d fs=%b expected 0 0 1",
               bus0.o_display_x_pos, bus0.o_display_y_pos, bus0.o_frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line();
    test_enable_freeze();
    test_frame();
    test_back_to_back();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Free-running VGA 640x480@60 timing generator clocked at the 25 MHz pixel clock. Produces horizontal/vertical sync and the raw display x/y position counters consumed by the pixel-drawing blocks (rectangle/paddle/ball renderers), plus active-video, line-start and frame-start qualifiers. It is the source end of the sync + position interface; downstream drawers add their own one-cycle delay to the syncs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- i_CLK  in  1  pixel clock, all logic on rising edge
- i_RST_N  in  1  reset, asynchronous assert, active-low
- i_enable  in  1  advance one pixel per clock when high; hold all state when low
- o_hSync  out  1  horizontal sync, active-low
- o_vSync  out  1  vertical sync, active-low
- o_display_x_pos  out  10  raw horizontal counter, 0..H_TOTAL-1
- o_display_y_pos  out  10  raw vertical counter, 0..V_TOTAL-1
- o_active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- o_line_start  out  1  high for the cycle where x == 0
- o_frame_start  out  1  high for the cycle where x == 0 and y == 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must fit in 10 bits.
- Horizontal axis phases ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, decided by x: ACTIVE x<640, FRONT 640..655, SYNC 656..751, BACK 752..799.
- Vertical phases same order by y: ACTIVE y<480, FRONT 480..489, SYNC 490..491, BACK 492..524.
- x increments each enabled clock; at x == H_TOTAL-1 it wraps to 0 and y increments. At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- o_hSync low only in horizontal SYNC phase; o_vSync low for every pixel of lines in vertical SYNC phase (changes coincide with x == 0).
- All outputs registered and mutually consistent: every output in a given cycle describes the same pixel (x, y).
- i_enable low: counters, phases and all outputs frozen, including single-cycle qualifiers (they stay high if frozen on their pixel).

## Timing
- Reset (asynchronous, i_RST_N low): x=0, y=0, o_hSync=1, o_vSync=1, o_active=0, o_line_start=0, o_frame_start=0.
- First enabled rising edge after reset release: outputs present pixel (0,0): o_active=1, o_line_start=1, o_frame_start=1, syncs high.
- Thereafter one pixel per enabled clock; line period 800 clocks, frame period 420000 clocks.
- Reset asserted mid-frame: immediate return to reset values; restart from (0,0) as above, no partial line.

## Configuration
- VGA_SYNC_FRAME_COUNT_EN defined: adds output o_frame_count (8 bits, reset 0) incrementing by 1 in the same cycle o_frame_start rises from a wrap (not on the first post-reset frame), wrapping 255 -> 0; used by game logic for frame-rate timing.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package vga_timing_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL derivation, and the four-value phase enum (ACTIVE, FRONT, SYNC, BACK).
- One sub-module vga_axis_counter (parameters ACTIVE/FP/SYNC/BP; inputs count enable; outputs position, phase, wrap flag), instantiated for horizontal (enable = i_enable) and vertical (enable = i_enable and horizontal wrap).

## Test plan
- Reset then release with i_enable=1 -> first edge x=0,y=0,o_frame_start=1,o_line_start=1,o_active=1,syncs high.
- Run one line -> x counts 0..799; o_hSync low exactly for x=656..751 (96 clocks); o_active low from x=640.
- Line wrap at x=799,y=0 -> next cycle x=0,y=1,o_line_start=1,o_frame_start=0.
- Run full frame -> o_vSync low exactly for y=490..491 (1600 clocks); (799,524) -> (0,0) with o_frame_start=1 after 420000 clocks; with VGA_SYNC_FRAME_COUNT_EN, o_frame_count 0 -> 1.
- i_enable low for 10 clocks at x=655 -> all outputs frozen; on re-enable x=656 and o_hSync falls.
- Assert i_RST_N low at (300,200) asynchronously -> outputs reach reset values without a clock edge; after release restart at (0,0).
